shift_register_sequencer: RTL and testbench

SHIFT_REGISTER_SEQUENCER -- requirements
Module: shift_register_sequencer

---
 rtl/shift_register_sequencer.sv | 86 ++++++++
 tb/tb_shift_register_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_register_sequencer.sv
// Step sequencer: divided clock advances a load/rotate/LFSR shift register gating a square-wave tone.
// Latency: data_in reaches state on the first step after 2 sync flops; step is one cycle after divider all-ones.
// Backpressure: none; short presses are latched in a capture flag until the next step consumes them.
module shift_register_sequencer #(
    parameter int WIDTH    = 6,
    parameter int DIV_BITS = 20,
    parameter int PITCH    = 7645,
    parameter logic [WIDTH-1:0] LFSR_TAPS = {2'b11, {(WIDTH-2){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] tap_mask,
    output logic [WIDTH-1:0] state,
    output logic             step,
    output logic             gate,
    output logic             audio_out
);
    localparam int OSC_W = (PITCH > 1) ? $clog2(PITCH) : 1;
    localparam logic [OSC_W-1:0] PITCH_LAST = OSC_W'(PITCH - 1);

    localparam logic [1:0] MODE_LOAD   = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_LFSR   = 2'b10;

    logic                sync_a;
    logic                sync_b;
    logic                capture;
    logic                step_q;
    logic                square;
    logic [DIV_BITS-1:0] div_cnt;
    logic [OSC_W-1:0]    osc_cnt;
    logic [WIDTH-1:0]    shreg;
    logic [WIDTH-1:0]    shreg_next;
    logic                new_bit;
    logic                fb;

    assign new_bit = capture | sync_b;
    // An all-zero register would lock the LFSR, so feed a 1 to escape.
    assign fb      = (shreg == '0) ? 1'b1 : ^(shreg & LFSR_TAPS);

    always_comb begin
        shreg_next = shreg;
        case (mode)
            MODE_LOAD:   shreg_next = {new_bit, shreg[WIDTH-1:1]};
            MODE_ROTATE: shreg_next = {shreg[0], shreg[WIDTH-1:1]};
            MODE_LFSR:   shreg_next = {fb, shreg[WIDTH-1:1]};
            default:     shreg_next = shreg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            capture <= 1'b0;
            step_q  <= 1'b0;
            div_cnt <= '0;
            shreg   <= '0;
            osc_cnt <= '0;
            square  <= 1'b0;
        end else begin
            sync_a  <= data_in;
            sync_b  <= sync_a;
            div_cnt <= div_cnt + 1'b1;
            // Registered wrap detect: step is high while the divider reads 0.
            step_q  <= &div_cnt;
            capture <= step_q ? 1'b0 : (capture | sync_b);
            if (step_q) begin
                shreg <= shreg_next;
            end
            if (osc_cnt == PITCH_LAST) begin
                osc_cnt <= '0;
                square  <= ~square;
            end else begin
                osc_cnt <= osc_cnt + 1'b1;
            end
        end
    end

    assign state     = shreg;
    assign step      = step_q;
    assign gate      = |(shreg & tap_mask);
    assign audio_out = square & gate;
endmodule

// File: tb/tb_shift_register_sequencer.sv
// Directed bench for shift_register_sequencer at WIDTH=6, DIV_BITS=3, PITCH=2.
module tb_shift_register_sequencer;
    logic       clk;
    logic       rst;
    logic       data_in;
    logic [1:0] mode;
    logic [5:0] tap_mask;
    logic [5:0] state;
    logic       step;
    logic       gate;
    logic       audio_out;

    int n_checks = 0;
    int n_errors = 0;

    shift_register_sequencer #(
        .WIDTH(6),
        .DIV_BITS(3),
        .PITCH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .mode(mode),
        .tap_mask(tap_mask),
        .state(state),
        .step(step),
        .gate(gate),
        .audio_out(audio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until step is seen, then one more clock so state has updated.
    task automatic wait_step(output int n);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (step) break;
        end
        if (!step) check("step_timeout", 32'(step), 32'd1);
        tick();
    endtask

    task automatic press();
        data_in = 1'b1;
        tick();
        data_in = 1'b0;
    endtask

    logic [5:0] rot_exp  [6] = '{6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b100000};
    logic       rot_gate [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [5:0] lfsr_exp [8] = '{6'b100000, 6'b110000, 6'b011000, 6'b101100,
                                 6'b110110, 6'b011011, 6'b101101, 6'b110110};
    logic [5:0] shift_exp[6] = '{6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b000000};

    initial begin
        int n;
        logic a [6];
        rst      = 1'b1;
        data_in  = 1'b0;
        mode     = 2'b00;
        tap_mask = 6'b100010;
        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_audio", 32'(audio_out), 32'd0);
        rst = 1'b0;
        check("post_rst_step", 32'(step), 32'd0);
        check("post_rst_audio", 32'(audio_out), 32'd0);

        // First step arrives 8 clocks after reset release.
        wait_step(n);
        check("first_step_delay", 32'(n), 32'd8);
        check("idle_step_state", 32'(state), 32'd0);

        // Load: a one-clock press mid-period lands at the MSB.
        tick();
        press();
        wait_step(n);
        check("load_msb", 32'(state), 32'b100000);
        for (int i = 0; i < 6; i++) begin
            wait_step(n);
            check($sformatf("load_shift%0d", i), 32'(state), 32'(shift_exp[i]));
        end

        // Rotate, with gate/audio checks along the way.
        press();
        wait_step(n);
        check("reload_msb", 32'(state), 32'b100000);
        mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            wait_step(n);
            check($sformatf("rot%0d", i), 32'(state), 32'(rot_exp[i]));
            check($sformatf("rot_gate%0d", i), 32'(gate), 32'(rot_gate[i]));
            if (i == 2 || i == 3) begin
                for (int k = 0; k < 6; k++) begin
                    a[k] = audio_out;
                    tick();
                end
                if (i == 2) begin
                    for (int k = 0; k < 6; k++) check($sformatf("audio_quiet%0d", k), 32'(a[k]), 32'd0);
                end else begin
                    for (int k = 0; k < 4; k++) check($sformatf("audio_toggle%0d", k), 32'(a[k] ^ a[k+2]), 32'd1);
                    check("audio_pairs", 32'((a[0] == a[1]) || (a[1] == a[2])), 32'd1);
                end
            end
        end

        // Hold: step keeps pulsing every 8 clocks, state frozen.
        mode = 2'b11;
        wait_step(n);
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            check($sformatf("hold_period%0d", i), 32'(n), 32'd7);
            check($sformatf("hold_state%0d", i), 32'(state), 32'b100000);
        end

        // Drain to zero in load mode, then run the LFSR from zero.
        mode = 2'b00;
        for (int i = 0; i < 7; i++) wait_step(n);
        check("drained", 32'(state), 32'd0);
        mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            wait_step(n);
            check($sformatf("lfsr%0d", i), 32'(state), 32'(lfsr_exp[i]));
        end
        for (int i = 0; i < 20; i++) begin
            wait_step(n);
            check($sformatf("lfsr_nonzero%0d", i), 32'(state != 6'd0), 32'd1);
        end

        // Reset at divider=5 with capture pending discards the press.
        mode = 2'b00;
        press();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_step", 32'(step), 32'd0);
        check("mid_rst_gate", 32'(gate), 32'd0);
        check("mid_rst_audio", 32'(audio_out), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rst_after_step", 32'(step), 32'd0);
        check("mid_rst_after_audio", 32'(audio_out), 32'd0);
        wait_step(n);
        check("mid_rst_step_delay", 32'(n), 32'd7);
        check("mid_rst_no_capture", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
